freq_meter: RTL

Gated-window frequency meter: the measuring end of the team's clock and tone generation. It counts rising edges of an asynchronous input (pulse sensor, or a looped-back `beep500`/`beep1k`/`Beep2k`/`ClkFsm` for self-test) over a programmable gate window of `Clk` cycles. It reports the edge count with a one-cycle valid strobe. It sits beside the frequency divider and feeds the health FSM and the 7-segment display path.

---
 rtl/freq_meter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// freq_meter: gated-window frequency meter.
// Counts rising edges of the asynchronous SigIn over a window of GATE_CYCLES
// Clk cycles and reports the count on Freq with a one-cycle Valid strobe.
// Build option: define FREQ_METER_FILTER_EN to insert a glitch filter of
// FILT_CYCLES after the synchronizer. Ports are identical in both builds.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 40_000_000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             SigIn,
  input  logic             Start,
  input  logic             Stop,
  output logic [CNT_W-1:0] Freq,
  output logic             Valid,
  output logic             Overflow,
  output logic             Busy
);

  localparam int unsigned      TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic               filt;
  logic               prev_q;
  logic               edge_pulse;
  logic [TMR_W-1:0]   timer_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               start_gate;
  logic               gate_end;

  // Reject illegal parameterisations at elaboration.
  if (GATE_CYCLES < 2 || FILT_CYCLES < 1) begin : g_param_check
    $error("freq_meter: GATE_CYCLES must be >= 2 and FILT_CYCLES >= 1");
  end

  // Two-flop synchronizer bringing SigIn into the Clk domain.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      sync_q <= '0;
    end else begin
      // NOTE: flops use non-blocking assignment so each stage samples the
      // value from before the edge; blocking here would collapse the chain.
      sync_q <= {sync_q[0], SigIn};
    end
  end

`ifdef FREQ_METER_FILTER_EN
  localparam int unsigned FC_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  logic [FC_W-1:0] filt_cnt_q;
  logic            filt_q;

  // Glitch filter: follow the synchronized level only after it has
  // disagreed with the filtered level for FILT_CYCLES consecutive cycles.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else if (sync_q[1] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FC_W'(FILT_CYCLES - 1)) begin
      filt_q     <= sync_q[1];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FC_W'(1);
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q[1];
`endif

  // Previous filtered level, for 0->1 edge detection.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= filt;
    end
  end

  assign edge_pulse = filt & ~prev_q;

  // FSM state register.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status outputs; Stop always beats Start.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d    = state_q;
    start_gate = 1'b0;
    gate_end   = 1'b0;
    Busy       = 1'b0;
    Valid      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start && !Stop) begin
          state_d    = S_GATE;
          start_gate = 1'b1;
        end
      end
      S_GATE: begin
        Busy = 1'b1;
        if (Stop) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d  = S_DONE;
          gate_end = 1'b1;
        end
      end
      S_DONE: begin
        Valid = 1'b1;
        if (Start && !Stop) begin
          state_d    = S_GATE;
          start_gate = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating edge count for this cycle, including the last gate cycle.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == S_GATE && edge_pulse) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Gate timer and edge counter; both are re-armed on every entry to GATE.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      timer_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (start_gate) begin
      timer_q <= TMR_LOAD;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == S_GATE && timer_q != '0) begin
        timer_q <= timer_q - TMR_W'(1);
      end
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Result registers load as GATE ends, so they are current while Valid is high.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      Freq     <= '0;
      Overflow <= 1'b0;
    end else if (gate_end) begin
      Freq     <= cnt_d;
      Overflow <= ovf_d;
    end
  end

endmodule
